// File: rtl/rr_arb32.sv
// Round-robin arbiter for the shared 32-to-1 selector: registered one-hot grant plus binary select.
// Optional hold-timeout forced release is enabled by defining ARB_TIMEOUT_EN.
module rr_arb32 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CW       = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] REQ,
  input  logic        DONE,
  output logic [31:0] G,
  output logic [4:0]  S,
  output logic        VALID,
  output logic        TO
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [4:0]  ptr;
  logic [4:0]  next_ptr;
  logic [5:0]  idle_pick;
  logic [5:0]  b2b_pick;
  logic        natural_rel;
  logic        forced_rel;

  if ((MAX_HOLD < 1) || (MAX_HOLD > 255) || ((MAX_HOLD >> CW) != 0)) begin : g_bad_params
    $error("rr_arb32: MAX_HOLD must be 1..255 and below 2**CW");
  end

  // Returns {found, index} of the first set bit scanning p, p+1, ... with wrap.
  function automatic logic [5:0] pick_first(input logic [31:0] r, input logic [4:0] p);
    logic [63:0] dbl;
    logic [31:0] rot;
    logic [5:0]  res;
    dbl = {r, r} >> p;
    rot = dbl[31:0];
    res = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      if (rot[31 - j]) res = {1'b1, p + 5'(31 - j)};
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] cnt;
  assign forced_rel = (cnt == CW'(MAX_HOLD - 1));
`else
  assign forced_rel = 1'b0;
`endif

  always_comb begin
    next_ptr    = S + 5'd1;
    idle_pick   = pick_first(REQ, ptr);
    b2b_pick    = pick_first(REQ & ~(32'h1 << S), next_ptr);
    natural_rel = DONE | ~REQ[S];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr   <= '0;
      G     <= '0;
      S     <= '0;
      VALID <= 1'b0;
      TO    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      TO <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_pick[5]) begin
            G     <= 32'h1 << idle_pick[4:0];
            S     <= idle_pick[4:0];
            VALID <= 1'b1;
            state <= BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          if (natural_rel || forced_rel) begin
            ptr <= next_ptr;
            // A natural release in the timeout cycle takes precedence, so no TO pulse.
            TO  <= forced_rel & ~natural_rel;
            if (b2b_pick[5]) begin
              G     <= 32'h1 << b2b_pick[4:0];
              S     <= b2b_pick[4:0];
              VALID <= 1'b1;
`ifdef ARB_TIMEOUT_EN
              cnt   <= '0;
`endif
            end else begin
              G     <= '0;
              S     <= '0;
              VALID <= 1'b0;
              state <= IDLE;
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (cnt != '1) cnt <= cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb32.sv
// Directed self-checking bench for rr_arb32; timeout expectations follow ARB_TIMEOUT_EN.
module tb_rr_arb32;

  logic        CLK;
  logic        RST_N;
  logic [31:0] REQ;
  logic        DONE;
  logic [31:0] G;
  logic [4:0]  S;
  logic        VALID;
  logic        TO;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  rr_arb32 #(.MAX_HOLD(4), .CW(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .DONE  (DONE),
    .G     (G),
    .S     (S),
    .VALID (VALID),
    .TO    (TO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] req_during);
    RST_N = 1'b0;
    REQ   = req_during;
    DONE  = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    REQ   = 32'hFFFF_FFFF;
    DONE  = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({G, S, VALID, TO} !== {32'h0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got G=%h S=%0d V=%b TO=%b, want G=0 S=0 V=0 TO=0", G, S, VALID, TO);
    end
    RST_N = 1'b1;
    tick();
    vectors++;
    if ({G, S, VALID, TO} !== {32'h1, 5'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_grant: got G=%h S=%0d V=%b TO=%b, want G=00000001 S=0 V=1 TO=0", G, S, VALID, TO);
    end
    DONE = 1'b1;
    tick();
    vectors++;
    if ({G, S, VALID, TO} !== {32'h2, 5'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_b2b_grant: got G=%h S=%0d V=%b TO=%b, want G=00000002 S=1 V=1 TO=0", G, S, VALID, TO);
    end
    DONE = 1'b0;
    REQ  = 32'h0;
    tick();
    vectors++;
    if ({G, S, VALID, TO} !== {32'h0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_to_idle: got G=%h S=%0d V=%b TO=%b, want G=0 S=0 V=0 TO=0", G, S, VALID, TO);
    end
  endtask

  task automatic test_wrap();
    do_reset(32'h0);
    REQ = 32'h8000_0001;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h1, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_first: got G=%h S=%0d V=%b, want G=00000001 S=0 V=1", G, S, VALID);
    end
    DONE = 1'b1;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h8000_0000, 5'd31, 1'b1}) begin
      errors++;
      $display("FAIL wrap_to_31: got G=%h S=%0d V=%b, want G=80000000 S=31 V=1", G, S, VALID);
    end
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h1, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_back_to_0: got G=%h S=%0d V=%b, want G=00000001 S=0 V=1", G, S, VALID);
    end
    DONE = 1'b0;
    REQ  = 32'h0;
    tick();
  endtask

  task automatic test_idle_wrap();
    do_reset(32'h0);
    REQ = 32'h0000_0020;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h20, 5'd5, 1'b1}) begin
      errors++;
      $display("FAIL single_grant5: got G=%h S=%0d V=%b, want G=00000020 S=5 V=1", G, S, VALID);
    end
    DONE = 1'b1;
    tick();
    vectors++;
    if ({G, S, VALID, TO} !== {32'h0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL release_to_idle: got G=%h S=%0d V=%b TO=%b, want G=0 S=0 V=0 TO=0", G, S, VALID, TO);
    end
    REQ = 32'h0;
    tick();
    vectors++;
    if ({G, VALID} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL done_in_idle: got G=%h V=%b, want G=0 V=0", G, VALID);
    end
    DONE = 1'b0;
    REQ  = 32'h0000_0008;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h8, 5'd3, 1'b1}) begin
      errors++;
      $display("FAIL ptr6_wrap_grant3: got G=%h S=%0d V=%b, want G=00000008 S=3 V=1", G, S, VALID);
    end
    REQ = 32'h0;
    tick();
  endtask

  task automatic test_withdraw();
    do_reset(32'h0);
    REQ = 32'h0000_0080;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h80, 5'd7, 1'b1}) begin
      errors++;
      $display("FAIL withdraw_grant7: got G=%h S=%0d V=%b, want G=00000080 S=7 V=1", G, S, VALID);
    end
    REQ = 32'h0000_0200;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h200, 5'd9, 1'b1}) begin
      errors++;
      $display("FAIL withdraw_b2b9: got G=%h S=%0d V=%b, want G=00000200 S=9 V=1", G, S, VALID);
    end
    REQ = 32'h0000_0202;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h200, 5'd9, 1'b1}) begin
      errors++;
      $display("FAIL other_req_no_effect: got G=%h S=%0d V=%b, want G=00000200 S=9 V=1", G, S, VALID);
    end
  endtask

  task automatic test_async_reset();
    do_reset(32'h0);
    REQ = 32'h0000_1000;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h1000, 5'd12, 1'b1}) begin
      errors++;
      $display("FAIL async_grant12: got G=%h S=%0d V=%b, want G=00001000 S=12 V=1", G, S, VALID);
    end
    #2 RST_N = 1'b0;
    #1;
    vectors++;
    if ({G, S, VALID, TO} !== {32'h0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_clear: got G=%h S=%0d V=%b TO=%b, want G=0 S=0 V=0 TO=0", G, S, VALID, TO);
    end
    REQ = 32'h0000_1001;
    #2 RST_N = 1'b1;
    tick();
    vectors++;
    if ({G, S, VALID} !== {32'h1, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_ptr_reset: got G=%h S=%0d V=%b, want G=00000001 S=0 V=1", G, S, VALID);
    end
  endtask

  task automatic test_timeout();
    do_reset(32'h0);
    REQ = 32'h0000_0004;
    tick();
    vectors++;
    if ({G, S, VALID, TO} !== {32'h4, 5'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL hold_grant2: got G=%h S=%0d V=%b TO=%b, want G=00000004 S=2 V=1 TO=0", G, S, VALID, TO);
    end
    REQ = 32'h0000_0014;
    repeat (3) tick();
    vectors++;
    if ({G, S, TO} !== {32'h4, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL hold_before_limit: got G=%h S=%0d TO=%b, want G=00000004 S=2 TO=0", G, S, TO);
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    vectors++;
    if ({G, S, VALID, TO} !== {32'h10, 5'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL timeout_release: got G=%h S=%0d V=%b TO=%b, want G=00000010 S=4 V=1 TO=1", G, S, VALID, TO);
    end
    tick();
    vectors++;
    if ({G, S, TO} !== {32'h10, 5'd4, 1'b0}) begin
      errors++;
      $display("FAIL timeout_pulse_end: got G=%h S=%0d TO=%b, want G=00000010 S=4 TO=0", G, S, TO);
    end
`else
    vectors++;
    if ({G, S, VALID, TO} !== {32'h4, 5'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL no_timeout_hold: got G=%h S=%0d V=%b TO=%b, want G=00000004 S=2 V=1 TO=0", G, S, VALID, TO);
    end
    repeat (20) tick();
    vectors++;
    if ({G, S, TO} !== {32'h4, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL no_timeout_long_hold: got G=%h S=%0d TO=%b, want G=00000004 S=2 TO=0", G, S, TO);
    end
`endif
  endtask

  initial begin
    RST_N = 1'b0;
    REQ   = 32'h0;
    DONE  = 1'b0;
    test_reset();
    test_wrap();
    test_idle_wrap();
    test_withdraw();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
